upsample_2x_stream: RTL
=======================

// Module: upsample_2x_stream
// PURPOSE
//  Streaming 2x bilinear upsampler: accepts an H x W frame of CH-channel pixels, row-major, over valid/ready.
//  Emits one 2x2 output block per input 2x2 window, for (H-1)*(W-1) output beats in total.
//  A one-row line buffer supplies the previous row, so no frame-level storage is needed.
//  Sits between a generator conv stage and the next stage.
// PARAMETERS
//  LENGTH  12  bits per channel sample, signed two's complement
//  FRAC    8   fraction bits of the fixed-point format; annotation only, arithmetic is format-agnostic
//  CH      1   channels per pixel; each channel is processed independently
//  MAX_W   64  max frame width; line-buffer depth
// PORTS
//  clk        in   1              clock, rising edge
//  rst        in   1              synchronous reset, active-high
//  start      in   1              frame start pulse; sampled only when busy=0
//  cfg_width  in   $clog2(MAX_W+1) frame width W, sampled on start
//  cfg_height in   16             frame height H, sampled on start
//  s_valid    in   1              input pixel valid
//  s_ready    out  1              input pixel accepted when s_valid&&s_ready
//  s_data     in   CH*LENGTH      input pixel, channel 0 in LSBs
//  m_valid    out  1              output block valid
//  m_ready    in   1              downstream ready
//  m_data     out  4*CH*LENGTH    {z,y,x,w}; w in LSBs; each field CH*LENGTH
//  m_first    out  1              first block of frame
//  m_eol      out  1              last block of an output row pair (input col W-1)
//  m_last     out  1              last block of frame
//  busy       out  1              state!=IDLE || m_valid
//  err        out  1              one-cycle pulse: start rejected
// BEHAVIOUR
//  Reset: state IDLE, counters 0, all outputs 0 (s_ready=0, m_valid=0, m_data=0, busy=0, err=0).
//   Line-buffer contents are don't-care. Reset mid-frame discards the partial frame.
//  FSM IDLE -> FILL on start with valid cfg (2<=W<=MAX_W, H>=2). Otherwise err=1 for one cycle and stay IDLE.
//   FILL: input row 0 is written to the line buffer; no output.
//   FILL -> RUN after col W-1 of row 0 is accepted.
//   RUN -> IDLE after col W-1 of row H-1 is accepted. The last output block may still be pending in m_*.
//  s_ready = (state==FILL||RUN) && (!m_valid || m_ready).
//  Counters col (0..W-1) and row (0..H-1) advance on each accepted beat; col wraps to 0 and row increments.
//  On each accepted beat:
//   - Read the line buffer at col, then write s_data at col.
//   - Hold regs keep the previous-column pixel of the buffered row and of the current row.
//  Output (RUN, col>=1): window a=in[row-1][col-1], b=in[row-1][col], c=in[row][col-1], d=in[row][col].
//   Per channel: w=(9a+3b+3c+d+8)>>>4, x=(3a+9b+c+3d+8)>>>4, y=(3a+b+9c+3d+8)>>>4, z=(a+3b+3c+9d+8)>>>4.
//   Intermediate sums are LENGTH+4 bits signed; result truncated to LENGTH bits. No overflow is possible (convex weights).
//  Latency: m_valid rises the cycle after the accepting edge. The output register holds while m_valid && !m_ready.
//  No output beat for col 0 or row 0; those beats only load state.
//  Output flags:
//   - m_first: row==1, col==1.
//   - m_eol: col==W-1.
//   - m_last: row==H-1, col==W-1.
//  Simultaneous m_ready and a new accept: the register is replaced in the same cycle, with no bubble.
//  start while busy is ignored (no err). s_valid while IDLE is not accepted.
// TESTING
//  1. Assert rst for 2 cycles -> all outputs 0, busy=0.
//  2. W=3,H=2, all samples 0x100, m_ready=1 -> 2 beats, all fields 0x100.
//     Beat 1 has m_first=1; beat 2 has m_eol=1 and m_last=1.
//  3. W=2,H=2, a=0,b=16,c=32,d=48 -> single beat w=12, x=20, y=28, z=36.
//     All samples 0xFFF -> all outputs 0xFFF.
//  4. W=8,H=6, random data, random m_ready -> 35 beats matching the golden model, in order.
//     s_ready=0 whenever m_valid && !m_ready.
//  5. start with cfg_width=1, then with cfg_width=MAX_W+1, then with cfg_height=1 -> err pulse each time; busy stays 0.
//  6. rst asserted mid-row 3 of a W=4,H=5 frame, then a new W=4,H=3 frame -> m_valid=0 after reset.
//     New frame gives exactly 6 correct beats.

Source files
------------

// File: rtl/upsample_2x_stream_if.sv
// Pixel-in / block-out stream bundle for upsample_2x_stream.
// The slave modport is the upsampler's view; master is the producer/consumer side around it.
interface upsample_2x_stream_if #(
  parameter int unsigned LENGTH = 12,
  parameter int unsigned CH     = 1
);
  logic                       s_valid;
  logic                       s_ready;
  logic [CH*LENGTH-1:0]       s_data;
  logic                       m_valid;
  logic                       m_ready;
  logic [4*CH*LENGTH-1:0]     m_data;
  logic                       m_first;
  logic                       m_eol;
  logic                       m_last;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_first, m_eol, m_last
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_first, m_eol, m_last
  );
endinterface

// File: rtl/upsample_2x_stream.sv
// Streaming 2x bilinear upsampler: one 2x2 output block per input 2x2 window,
// using a single-row line buffer and two previous-column hold registers.
module upsample_2x_stream #(
  parameter int unsigned LENGTH = 12,
  parameter int unsigned FRAC   = 8,
  parameter int unsigned CH     = 1,
  parameter int unsigned MAX_W  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(MAX_W+1)-1:0] cfg_width,
  input  logic [15:0]                cfg_height,
  upsample_2x_stream_if.slave        bus,
  output logic                       busy,
  output logic                       err
);
  localparam int unsigned WW = $clog2(MAX_W+1);
  localparam int unsigned AW = $clog2(MAX_W);
  localparam int unsigned PW = CH*LENGTH;
  localparam int unsigned SW = LENGTH+4;

  // FRAC only documents the sample format; the blend arithmetic never needs it.
  if (FRAC > LENGTH) begin : g_frac_annotation
  end

  typedef enum logic [1:0] {IDLE, FILL, RUN} state_t;

  state_t          state_q, state_d;
  logic [WW-1:0]   width_q, width_d, col_q, col_d;
  logic [15:0]     height_q, height_d, row_q, row_d;
  logic [PW-1:0]   prev_top_q, prev_top_d, prev_cur_q, prev_cur_d;
  logic [4*PW-1:0] m_data_q, m_data_d;
  logic            m_valid_q, m_valid_d, m_first_q, m_first_d;
  logic            m_eol_q, m_eol_d, m_last_q, m_last_d, err_q, err_d;
  logic [PW-1:0]   lbuf_q [MAX_W];
  logic [PW-1:0]   top_rd;
  logic [4*PW-1:0] blk;
  logic            accept, s_ready, col_last, row_last, cfg_ok, lbuf_we;

  // Weights (9,3,3,1)/16 with round-half-up; sums are LENGTH+4 bits signed.
  function automatic logic [LENGTH-1:0] mix(input logic [LENGTH-1:0] p9, p3a, p3b, p1);
    logic signed [SW-1:0] e9, e3a, e3b, e1, sum;
    e9  = {{4{p9[LENGTH-1]}},  p9};
    e3a = {{4{p3a[LENGTH-1]}}, p3a};
    e3b = {{4{p3b[LENGTH-1]}}, p3b};
    e1  = {{4{p1[LENGTH-1]}},  p1};
    sum = (e9 <<< 3) + e9 + (e3a <<< 1) + e3a + (e3b <<< 1) + e3b + e1 + SW'(8);
    sum = sum >>> 4;
    return sum[LENGTH-1:0];
  endfunction

  assign top_rd   = lbuf_q[col_q[AW-1:0]];
  assign s_ready  = (state_q != IDLE) && (!m_valid_q || bus.m_ready);
  assign accept   = bus.s_valid && s_ready;
  assign col_last = (col_q == width_q - WW'(1));
  assign row_last = (row_q == height_q - 16'd1);
  assign cfg_ok   = (cfg_width >= WW'(2)) && (cfg_width <= WW'(MAX_W)) && (cfg_height >= 16'd2);
  assign busy     = (state_q != IDLE) || m_valid_q;
  assign err      = err_q;

  assign bus.s_ready = s_ready;
  assign bus.m_valid = m_valid_q;
  assign bus.m_data  = m_data_q;
  assign bus.m_first = m_first_q;
  assign bus.m_eol   = m_eol_q;
  assign bus.m_last  = m_last_q;

  // Window: a=prev_top_q, b=top_rd, c=prev_cur_q, d=s_data; fields {z,y,x,w}.
  always_comb begin
    logic [LENGTH-1:0] a, b, c, d;
    blk = '0;
    for (int unsigned k = 0; k < CH; k++) begin
      a = prev_top_q[k*LENGTH +: LENGTH];
      b = top_rd[k*LENGTH +: LENGTH];
      c = prev_cur_q[k*LENGTH +: LENGTH];
      d = bus.s_data[k*LENGTH +: LENGTH];
      blk[0*PW + k*LENGTH +: LENGTH] = mix(a, b, c, d);
      blk[1*PW + k*LENGTH +: LENGTH] = mix(b, a, d, c);
      blk[2*PW + k*LENGTH +: LENGTH] = mix(c, a, d, b);
      blk[3*PW + k*LENGTH +: LENGTH] = mix(d, b, c, a);
    end
  end

  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    height_d   = height_q;
    col_d      = col_q;
    row_d      = row_q;
    prev_top_d = prev_top_q;
    prev_cur_d = prev_cur_q;
    m_valid_d  = m_valid_q && !bus.m_ready;
    m_data_d   = m_data_q;
    m_first_d  = m_first_q;
    m_eol_d    = m_eol_q;
    m_last_d   = m_last_q;
    err_d      = 1'b0;
    lbuf_we    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !busy) begin
          if (cfg_ok) begin
            width_d  = cfg_width;
            height_d = cfg_height;
            col_d    = '0;
            row_d    = '0;
            state_d  = FILL;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      FILL:    if (accept && col_last) state_d = RUN;
      RUN:     if (accept && col_last && row_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      lbuf_we    = 1'b1;
      prev_top_d = top_rd;
      prev_cur_d = bus.s_data;
      if (col_last) begin
        col_d = '0;
        row_d = row_q + 16'd1;
      end else begin
        col_d = col_q + WW'(1);
      end
      if (state_q == RUN && col_q != '0) begin
        m_valid_d = 1'b1;
        m_data_d  = blk;
        m_first_d = (row_q == 16'd1) && (col_q == WW'(1));
        m_eol_d   = col_last;
        m_last_d  = col_last && row_last;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      width_q    <= '0;
      height_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
      prev_top_q <= '0;
      prev_cur_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_first_q  <= 1'b0;
      m_eol_q    <= 1'b0;
      m_last_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      width_q    <= width_d;
      height_q   <= height_d;
      col_q      <= col_d;
      row_q      <= row_d;
      prev_top_q <= prev_top_d;
      prev_cur_q <= prev_cur_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_first_q  <= m_first_d;
      m_eol_q    <= m_eol_d;
      m_last_q   <= m_last_d;
      err_q      <= err_d;
    end
  end

  // Read-before-write: the combinational read above sees the previous row's sample.
  always_ff @(posedge clk) begin
    if (lbuf_we) lbuf_q[col_q[AW-1:0]] <= bus.s_data;
  end
endmodule
